// File: rtl/bnn_param_loader.sv
// Serial configuration loader for a daisy-chain of binary neurons: serializes host bytes
// MSB-first into the chain head and captures the bits leaving the chain tail as readback bytes.
module bnn_param_loader #(
    parameter int unsigned NEURONS    = 4,
    parameter int unsigned INPUTS     = 8,
    parameter int unsigned BIAS_BITS  = 3,
    parameter int unsigned TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS),
    parameter int unsigned CNT_W      = $clog2(TOTAL_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             setup,
    output logic             param_out,
    input  logic             chain_in,
    output logic [7:0]       rb_data,
    output logic             rb_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {StIdle, StWaitByte, StShift, StDone} state_e;

    state_e           state_q;
    logic [7:0]       byte_q;
    logic [7:0]       rb_shift_q;
    logic [7:0]       rb_data_q;
    logic             rb_valid_q;
    logic [2:0]       byte_cnt_q;
    logic [CNT_W-1:0] bit_count_q;

    logic       last_bit;
    logic       byte_end;
    logic [7:0] rb_next;
    logic [3:0] rb_fill;
    logic [7:0] rb_aligned;

    assign last_bit = (bit_count_q == CNT_W'(TOTAL_BITS - 1));
    assign byte_end = (byte_cnt_q == 3'd7);
    assign rb_next  = {rb_shift_q[6:0], chain_in};
    // Number of readback bits gathered for the current byte, including this cycle's sample;
    // shifting by the remainder left-aligns a short final byte with zero LSBs.
    assign rb_fill    = {1'b0, byte_cnt_q} + 4'd1;
    assign rb_aligned = rb_next << (4'd8 - rb_fill);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            byte_q      <= '0;
            rb_shift_q  <= '0;
            rb_data_q   <= '0;
            rb_valid_q  <= 1'b0;
            byte_cnt_q  <= '0;
            bit_count_q <= '0;
        end else begin
            rb_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StWaitByte;
                        bit_count_q <= '0;
                        byte_cnt_q  <= '0;
                    end
                end
                StWaitByte: begin
                    if (in_valid) begin
                        byte_q     <= in_data;
                        byte_cnt_q <= '0;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    byte_q      <= {byte_q[6:0], 1'b0};
                    bit_count_q <= bit_count_q + CNT_W'(1);
                    byte_cnt_q  <= byte_cnt_q + 3'd1;
                    rb_shift_q  <= rb_next;
                    if (last_bit || byte_end) begin
                        rb_data_q  <= rb_aligned;
                        rb_valid_q <= 1'b1;
                    end
                    if (last_bit) begin
                        state_q <= StDone;
                    end else if (byte_end) begin
                        state_q <= StWaitByte;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // All chain-facing outputs come straight from registers so the neurons see stable values.
    assign in_ready  = (state_q == StWaitByte);
    assign setup     = (state_q == StShift);
    assign param_out = (state_q == StShift) ? byte_q[7] : 1'b0;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rb_data   = rb_data_q;
    assign rb_valid  = rb_valid_q;
    assign bit_count = bit_count_q;

endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
- Sequences serial configuration of a daisy-chain of binary neurons. Each neuron stores INPUTS weight bits and BIAS_BITS bias bits, loaded through a setup/param_in/param_out shift chain.
- Accepts configuration bytes from a host over a valid/ready handshake and serializes them MSB-first into the chain head while holding setup high.
- Captures the bits leaving the chain tail as readback bytes.
- Sits between the host interface and the neuron layer.

Parameters:
- NEURONS, 4, number of neurons in the chain.
- INPUTS, 8, weight bits per neuron.
- BIAS_BITS, 3, bias bits per neuron.
- TOTAL_BITS, NEURONS*(INPUTS+BIAS_BITS) = 44, derived; chain length in bits.
- CNT_W, $clog2(TOTAL_BITS+1), derived; width of bit_count.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; honoured only in IDLE.
- in_data  in  8  configuration byte, MSB shifted first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- setup  out  1  chain shift enable, drives every neuron's setup input.
- param_out  out  1  serial bit to the chain head param_in.
- chain_in  in  1  serial bit from the chain tail param_out.
- rb_data  out  8  readback byte, left-aligned.
- rb_valid  out  1  one-cycle strobe, rb_data is valid.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the load completes.
- bit_count  out  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset values: FSM=IDLE; in_ready=0, setup=0, param_out=0, rb_valid=0, rb_data=0, busy=0, done=0, bit_count=0; shift and readback registers cleared.
- FSM has four states: IDLE, WAIT_BYTE, SHIFT, DONE.
  - IDLE: start=1 moves to WAIT_BYTE and clears bit_count and the per-byte counter. All other inputs are ignored.
  - WAIT_BYTE: in_ready=1, setup=0. On in_valid&in_ready, in_data loads the byte register and the FSM moves to SHIFT. If in_valid is low, the FSM stalls indefinitely with setup=0.
  - SHIFT: setup=1, param_out=byte_reg[7]. Each cycle: byte_reg shifts left with 0 fill, bit_count increments, per-byte counter increments.
    - If bit_count reaches TOTAL_BITS, go to DONE.
    - Else, if 8 bits of the byte have been shifted, go to WAIT_BYTE.
    - Else, stay in SHIFT.
  - DONE: done=1 for exactly one cycle, then IDLE.
- setup and param_out are decoded from registered state only (no input-to-output path), so the neurons sample them at the next rising edge.
- Timing: a byte accepted at edge N gives setup=1 during cycles N+1..N+8. Steady-state throughput is 9 cycles per byte.
- Bytes consumed per load = ceil(TOTAL_BITS/8) = 6 at defaults. Only the upper TOTAL_BITS mod 8 bits (4 at defaults) of the final byte are shifted; the rest are discarded.
- Bit order is the stream order; the loader does no reordering. The first bit shifted ends in the tail neuron's bias MSB.
- Readback:
  - Each SHIFT cycle, chain_in is sampled into rb_shift at the LSB, shifting left.
  - After each 8th sampled bit, and after the final bit of the load, rb_data is updated and rb_valid pulses for one cycle (the cycle after the last sampled bit).
  - A partial final byte is left-aligned with zero LSBs (e.g. 4 bits b3..b0 give {b3..b0,0000}).
- start while busy=1: ignored, no restart.
- in_valid outside WAIT_BYTE: ignored, in_ready=0, byte not consumed.
- Reset mid-load: the next cycle is IDLE with setup=0 and bit_count=0. Neuron contents are left partially shifted (neurons have no reset); the host must reload.
- done and rb_valid may assert in the same cycle on the final byte.
- bit_count holds its final value (TOTAL_BITS) after DONE until the next start or reset.

Test Plan:
- Reset with random inputs for 5 cycles → all outputs 0, in_ready=0, FSM in IDLE; start pulse → in_ready=1 next cycle.
- start, then bytes A5,3C,FF,00,81,E0 with continuous valid → setup high exactly 44 cycles in 6 bursts (8,8,8,8,8,4). param_out sequence = A5 3C FF 00 81 E msb-first. done pulses once; bit_count=44. A 44-bit chain model matches, and neuron 0's weights/bias equal the last 11 bits streamed.
- Same load with in_valid deasserted for 3 cycles between every byte → setup=0 during stalls; identical final chain contents; no bits lost or duplicated.
- Load pattern P1 = 12,34,56,78,9A,B0, then load P2 = FF×6 → the rb bytes during the second load are 12,34,56,78,9A,B0. The last rb byte is B0 (partial byte left-aligned, zero-filled), coincident with done.
- start asserted repeatedly mid-load → no restart, bit_count keeps counting. Reset asserted at bit_count=20 → next cycle setup=0, busy=0, bit_count=0; a new start then consumes a full 6 bytes / 44 bits.
- Final byte 0x3C → only bits 0,0,1,1 are driven on param_out. The next byte offered after done is not accepted (in_ready=0 in IDLE).
